// File: rtl/branch_resolver.sv
// Decode-stage branch/jump resolver: evaluates B-type conditions, forms JAL/JALR targets,
// and strobes each control-flow instruction's outcome exactly once. Optional perf counters: BRU_PERF_CNT_EN.
module branch_resolver #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             id_valid,
    input  logic             ext_hold,
    input  logic             flush,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  imm,
    input  logic [PC_W-1:0]  rs1_val,
    input  logic [PC_W-1:0]  rs2_val,
    input  logic             rs1_rdy,
    input  logic             rs2_rdy,
    output logic             b_eval,
    output logic             branch_outcome,
    output logic             trgt_gen,
    output logic             jr_bpu,
    output logic [PC_W-1:0]  alupc,
    output logic [PC_W-1:0]  pcplf,
    output logic [PC_W-1:0]  jr_in,
    output logic             stall,
    output logic             illegal_br,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_jump
);
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    state_t state;

    logic is_b, is_jal, is_jalr, is_cf, ready, active, fire, taken;
    logic [PC_W-1:0] jr_sum;

    assign is_b    = (op == OP_BR);
    assign is_jal  = (op == OP_JAL);
    assign is_jalr = (op == OP_JALR);
    assign is_cf   = is_b | is_jal | is_jalr;

    assign ready = is_b ? (rs1_rdy & rs2_rdy) : (is_jalr ? rs1_rdy : 1'b1);

    // Outputs are gated by nrst so a reset cycle can never leak a strobe or stall.
    assign active = nrst & id_valid & is_cf & ~flush & (state != S_DONE);
    assign fire   = active & ready;
    assign stall  = active & ~ready;

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000: taken = (rs1_val == rs2_val);
            3'b001: taken = (rs1_val != rs2_val);
            3'b100: taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101: taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: taken = (rs1_val <  rs2_val);
            3'b111: taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

    assign b_eval         = fire & is_b;
    assign branch_outcome = b_eval & taken;
    assign trgt_gen       = fire & is_jal;
    assign jr_bpu         = fire & is_jalr;
    assign illegal_br     = nrst & id_valid & is_b & (funct3[2:1] == 2'b01);

    assign alupc  = pc + imm;
    assign pcplf  = pc + PC_W'(4);
    assign jr_sum = rs1_val + imm;
    assign jr_in  = {jr_sum[PC_W-1:1], 1'b0};

    always_ff @(posedge clk) begin
        if (!nrst || flush) begin
            state <= S_IDLE;
        end else if (!id_valid) begin
            if (!ext_hold) state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_WAIT: begin
                    if (!is_cf)     state <= S_IDLE;
                    else if (ready) state <= ext_hold ? S_DONE : S_IDLE;
                    else            state <= S_WAIT;
                end
                S_DONE:  state <= ext_hold ? S_DONE : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_branch <= '0;
            cnt_taken  <= '0;
            cnt_jump   <= '0;
        end else begin
            if (b_eval)              cnt_branch <= cnt_branch + CNT_W'(1);
            if (branch_outcome)      cnt_taken  <= cnt_taken  + CNT_W'(1);
            if (trgt_gen || jr_bpu)  cnt_jump   <= cnt_jump   + CNT_W'(1);
        end
    end
`else
    assign cnt_branch = '0;
    assign cnt_taken  = '0;
    assign cnt_jump   = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed scenarios plus randomized traffic checked against
// an instruction-level model ("has the instruction sitting in decode been resolved yet").
module tb_branch_resolver;
    localparam int PC_W = 32, CNT_W = 32;
    localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_ALU = 7'b0110011;

    logic clk = 1'b0, nrst, id_valid, ext_hold, flush, rs1_rdy, rs2_rdy;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [PC_W-1:0] pc, imm, rs1_val, rs2_val, alupc, pcplf, jr_in;
    logic b_eval, branch_outcome, trgt_gen, jr_bpu, stall, illegal_br;
    logic [CNT_W-1:0] cnt_branch, cnt_taken, cnt_jump;

    branch_resolver #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .nrst(nrst), .id_valid(id_valid), .ext_hold(ext_hold), .flush(flush),
        .op(op), .funct3(funct3), .pc(pc), .imm(imm), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rs1_rdy(rs1_rdy), .rs2_rdy(rs2_rdy), .b_eval(b_eval), .branch_outcome(branch_outcome),
        .trgt_gen(trgt_gen), .jr_bpu(jr_bpu), .alupc(alupc), .pcplf(pcplf), .jr_in(jr_in),
        .stall(stall), .illegal_br(illegal_br), .cnt_branch(cnt_branch), .cnt_taken(cnt_taken),
        .cnt_jump(cnt_jump)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference state: resolved flag for the held instruction and expected counter values.
    bit m_done;
    bit m_fire_b, m_fire_t, m_fire_j, m_stall;
    logic [CNT_W-1:0] m_cb = '0, m_ct = '0, m_cj = '0;

    function automatic bit cond_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic eval();
        bit isb, isj, isjr, cf, rdy, act, fire, tk;
        logic [PC_W-1:0] e_jr;
        @(negedge clk);
        isb = (op == OP_BR); isj = (op == OP_JAL); isjr = (op == OP_JALR);
        cf = isb || isj || isjr;
        rdy = isb ? (rs1_rdy && rs2_rdy) : (isjr ? rs1_rdy : 1'b1);
        act = nrst && id_valid && cf && !flush && !m_done;
        fire = act && rdy;
        tk = cond_taken(funct3, rs1_val, rs2_val);
        m_fire_b = fire && isb; m_fire_t = m_fire_b && tk; m_fire_j = fire && (isj || isjr);
        m_stall = act && !rdy;
        e_jr = rs1_val + imm; e_jr[0] = 1'b0;
        chk("b_eval", b_eval, m_fire_b);
        chk("branch_outcome", branch_outcome, m_fire_t);
        chk("trgt_gen", trgt_gen, fire && isj);
        chk("jr_bpu", jr_bpu, fire && isjr);
        chk("stall", stall, m_stall);
        chk("illegal_br", illegal_br, nrst && id_valid && isb && (funct3 == 3'd2 || funct3 == 3'd3));
        chk("alupc", alupc, PC_W'(pc + imm));
        chk("pcplf", pcplf, PC_W'(pc + 32'd4));
        chk("jr_in", jr_in, e_jr);
`ifdef BRU_PERF_CNT_EN
        chk("cnt_branch", cnt_branch, m_cb);
        chk("cnt_taken", cnt_taken, m_ct);
        chk("cnt_jump", cnt_jump, m_cj);
`else
        chk("cnt_zero", {cnt_branch, cnt_taken}, 64'd0);
        chk("cnt_jump_zero", cnt_jump, 64'd0);
`endif
    endtask

    task automatic adv();
        @(posedge clk);
        if (!nrst) begin
            m_done = 0; m_cb = '0; m_ct = '0; m_cj = '0;
        end else begin
            m_cb += CNT_W'(m_fire_b); m_ct += CNT_W'(m_fire_t); m_cj += CNT_W'(m_fire_j);
            if (flush)          m_done = 0;
            else if (!id_valid) m_done = ext_hold ? m_done : 1'b0;
            else if (m_done)    m_done = ext_hold;
            else                m_done = (m_fire_b || m_fire_j) && ext_hold;
        end
        #1;
    endtask

    task automatic cyc(); eval(); adv(); endtask

    task automatic set_ins(input logic [6:0] o, input logic [2:0] f, input logic [31:0] p,
                           input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        op = o; funct3 = f; pc = p; imm = i; rs1_val = a; rs2_val = b;
        id_valid = 1; rs1_rdy = 1; rs2_rdy = 1; ext_hold = 0; flush = 0;
    endtask

    initial begin
        bit newi;
        int sel;
        nrst = 0;
        set_ins(OP_BR, 3'd0, 32'h100, 32'h20, 32'h5, 32'h5);
        cyc();
        eval(); chk("reset_no_strobe", b_eval, 1'b0); chk("reset_no_stall", stall, 1'b0); adv();
        nrst = 1;

        // BEQ equal operands, ready on arrival
        eval();
        chk("tp_beq_eval", b_eval, 1'b1); chk("tp_beq_taken", branch_outcome, 1'b1);
        chk("tp_beq_alupc", alupc, 32'h120); chk("tp_beq_pcplf", pcplf, 32'h104);
        chk("tp_beq_stall", stall, 1'b0);
        adv();

        // BLT waits two cycles on rs2
        set_ins(OP_BR, 3'd4, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1); rs2_rdy = 0;
        for (int k = 0; k < 2; k++) begin
            eval(); chk("tp_blt_stall", stall, 1'b1); chk("tp_blt_noeval", b_eval, 1'b0); adv();
        end
        rs2_rdy = 1;
        eval(); chk("tp_blt_eval", b_eval, 1'b1); chk("tp_blt_taken", branch_outcome, 1'b1);
        chk("tp_blt_stall_off", stall, 1'b0); adv();
        set_ins(OP_BR, 3'd6, 32'h204, 32'h40, 32'hFFFF_FFFF, 32'h1);
        eval(); chk("tp_bltu_eval", b_eval, 1'b1); chk("tp_bltu_taken", branch_outcome, 1'b0); adv();

        // JAL held three cycles: one strobe only
        set_ins(OP_JAL, 3'd0, 32'h300, 32'h80, 32'h0, 32'h0); ext_hold = 1;
        eval(); chk("tp_jal_c1", trgt_gen, 1'b1); adv();
        eval(); chk("tp_jal_c2", trgt_gen, 1'b0); adv();
        eval(); chk("tp_jal_c3", trgt_gen, 1'b0); adv();
        ext_hold = 0;
        eval(); chk("tp_jal_c4", trgt_gen, 1'b0); adv();

        // JALR target and flush during WAIT
        set_ins(OP_JALR, 3'd0, 32'h400, 32'h4, 32'h203, 32'h0);
        eval(); chk("tp_jalr", jr_bpu, 1'b1); chk("tp_jalr_in", jr_in, 32'h206); adv();
        set_ins(OP_JALR, 3'd0, 32'h404, 32'h8, 32'h500, 32'h0); rs1_rdy = 0;
        eval(); chk("tp_wait_stall", stall, 1'b1); adv();
        rs1_rdy = 1; flush = 1;
        eval(); chk("tp_flush_nostrobe", jr_bpu, 1'b0); chk("tp_flush_nostall", stall, 1'b0); adv();
        set_ins(OP_JAL, 3'd0, 32'h600, 32'h10, 32'h0, 32'h0);
        eval(); chk("tp_after_flush_idle", trgt_gen, 1'b1); adv();

        // Illegal funct3, then counter scenario from reset
        nrst = 0; cyc(); nrst = 1;
        set_ins(OP_BR, 3'd2, 32'h700, 32'h8, 32'h9, 32'h9);
        eval(); chk("tp_ill_flag", illegal_br, 1'b1); chk("tp_ill_eval", b_eval, 1'b1);
        chk("tp_ill_taken", branch_outcome, 1'b0); adv();
        set_ins(OP_BR, 3'd1, 32'h704, 32'h8, 32'h1, 32'h2); cyc();
        set_ins(OP_BR, 3'd7, 32'h708, 32'h8, 32'h3, 32'h2); cyc();
        set_ins(OP_JAL, 3'd0, 32'h70C, 32'h8, 32'h0, 32'h0); cyc();
        set_ins(OP_ALU, 3'd0, 32'h710, 32'h8, 32'h0, 32'h0);
        eval();
`ifdef BRU_PERF_CNT_EN
        chk("tp_cnt_branch", cnt_branch, 32'd3); chk("tp_cnt_taken", cnt_taken, 32'd2);
        chk("tp_cnt_jump", cnt_jump, 32'd1);
`endif
        adv();
        nrst = 0; cyc(); nrst = 1;

        // Randomized traffic; instruction fields stay put while decode is held
        newi = 1;
        for (int i = 0; i < 2000; i++) begin
            if (newi) begin
                sel = $urandom_range(0, 5);
                op = (sel < 3) ? OP_BR : (sel == 3) ? OP_JAL : (sel == 4) ? OP_JALR : OP_ALU;
                funct3 = 3'($urandom);
                pc = $urandom & ~32'h3;
                imm = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(12'($urandom)));
                rs1_val = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
                rs2_val = ($urandom_range(0, 2) == 0) ? rs1_val : $urandom;
            end
            rs1_rdy  = ($urandom_range(0, 9) < 7);
            rs2_rdy  = ($urandom_range(0, 9) < 7);
            ext_hold = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            id_valid = ($urandom_range(0, 9) != 0);
            nrst     = ($urandom_range(0, 49) != 0);
            cyc();
            newi = !(m_stall || ext_hold) || flush || !nrst;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Decode-stage branch/jump resolution unit producing the resolution side of the branch prediction handshake: it evaluates conditional branches, generates JAL/JALR targets, and pulses the outcome strobes (`b_eval`, `branch_outcome`, `trgt_gen`, `jr_bpu`) exactly once per control-flow instruction. It sits between the decode register/forwarding network and the BPU. It stalls fetch while branch operands are not yet forwarded.

## Interface
- `PC_W`, 32, PC and operand width
- `CNT_W`, 32, performance counter width (only with `BRU_PERF_CNT_EN`)

- `clk  in  1  clock, posedge`
- `nrst  in  1  reset, synchronous, active-low`
- `id_valid  in  1  decode register holds a valid instruction`
- `ext_hold  in  1  decode register holds its instruction next cycle (other hazard)`
- `flush  in  1  kill instruction in decode this cycle`
- `op  in  7  opcode in decode`
- `funct3  in  3  branch condition`
- `pc  in  PC_W  PC of decode instruction`
- `imm  in  PC_W  sign-extended B/J/I immediate`
- `rs1_val, rs2_val  in  PC_W  forwarded operands`
- `rs1_rdy, rs2_rdy  in  1  operand valid after forwarding`
- `b_eval  out  1  branch outcome valid (1-cycle pulse)`
- `branch_outcome  out  1  1 = taken`
- `trgt_gen  out  1  JAL target valid (1-cycle pulse)`
- `jr_bpu  out  1  JALR target valid (1-cycle pulse)`
- `alupc  out  PC_W  pc + imm`
- `pcplf  out  PC_W  pc + 4`
- `jr_in  out  PC_W  (rs1_val + imm) & ~1`
- `stall  out  1  hold PC/fetch (drives pc_en low)`
- `illegal_br  out  1  B-type with funct3 = 010/011`
- `cnt_branch, cnt_taken, cnt_jump  out  CNT_W  perf counters`

## Operation
- Decode classes: B-type op 1100011, JAL 1101111, JALR 1100111; anything else is a non-CF instruction.
- Conditions (funct3): 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU. For 010/011: outcome 0 and `illegal_br` = 1 while in decode, but `b_eval` still pulses.
- Readiness: B-type needs `rs1_rdy & rs2_rdy`; JALR needs `rs1_rdy`; JAL is always ready.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: a valid CF instruction that is ready fires its strobe this cycle. Next state is DONE if `ext_hold`, else IDLE. If it is not ready: no strobe, `stall` = 1, next state WAIT.
  - WAIT: `stall` = 1 until ready. When ready, fire the strobe. Next state is DONE if `ext_hold`, else IDLE.
  - DONE: strobes suppressed. Stay while `ext_hold` = 1; go to IDLE when `ext_hold` = 0.
- `flush` = 1 in any state suppresses strobes and `stall` that cycle, and forces the next state to IDLE.
- `id_valid` = 0 means no strobes and no stall; the FSM goes to IDLE unless `ext_hold`.
- `alupc`, `pcplf`, `jr_in` are combinational and always driven. Adds are modulo 2^PC_W, with no carry out.
- `branch_outcome` is meaningful only when `b_eval` = 1. It is 0 otherwise.

## Timing
- Strobes are combinational from the FSM state and inputs, in the same cycle the operands become ready. The BPU samples them at the next posedge.
- Latency: 0 cycles when ready on arrival; otherwise n cycles, where n = cycles until ready.
- Exactly one strobe per instruction, regardless of how long `ext_hold` lasts.
- `stall` deasserts in the cycle the strobe fires.
- Reset values: state IDLE; all strobes, `stall`, `illegal_br` = 0; counters = 0.
- Reset asserted mid-WAIT abandons the instruction, and no strobe is emitted.
- Both `flush` and ready in the same cycle: `flush` wins, no strobe.

## Configuration
- `BRU_PERF_CNT_EN` defined:
  - `cnt_branch` +1 per `b_eval`.
  - `cnt_taken` +1 per `b_eval & branch_outcome`.
  - `cnt_jump` +1 per `trgt_gen | jr_bpu`.
  - All counters wrap at 2^CNT_W and clear on reset.
- Not defined: counter ports exist but are tied to 0, and no counter flops are synthesized.

## Test plan
- BEQ with rs1 = rs2 = 0x5, both ready, `pc` = 0x100, `imm` = 0x20 -> same cycle `b_eval` = 1, `branch_outcome` = 1, `alupc` = 0x120, `pcplf` = 0x104, `stall` = 0.
- BLT with rs1 = 0xFFFFFFFF, rs2 = 0x1, `rs2_rdy` low for 2 cycles -> `stall` = 1 for 2 cycles, then one `b_eval` with outcome 1. BLTU with the same operands -> outcome 0.
- JAL held by `ext_hold` for 3 cycles -> `trgt_gen` pulses only in cycle 1, then DONE, then back to IDLE.
- JALR with rs1 = 0x203, `imm` = 0x4 -> `jr_bpu` = 1, `jr_in` = 0x206. Flush during WAIT -> no strobe, `stall` drops, state IDLE.
- B-type with funct3 = 010 -> `illegal_br` = 1, `b_eval` = 1, outcome 0. With `BRU_PERF_CNT_EN`, after 3 branches (2 taken) and 1 JAL: `cnt_branch` = 3, `cnt_taken` = 2, `cnt_jump` = 1. Reset -> all 0.
